// File: rtl/run_ctrl.sv
// Run control and RAM arbiter for the 8-bit accumulator CPU: gates cpu_en_o (run/halt/step/breakpoint) and lends the RAM to host commands.
// Commands act from the cycle after acceptance; cmd_ready_o drops in STEP and MEM; responses are one-cycle pulses with no backpressure.
module run_ctrl #(
   parameter int AW      = 5,
   parameter int DW      = 8,
   parameter bit RST_RUN = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [2:0]    cmd_op_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [DW-1:0] cmd_data_i,
   output logic          rsp_valid_o,
   output logic [DW-1:0] rsp_data_o,
   output logic          halted_o,
   output logic          cpu_en_o,
   input  logic [AW-1:0] pc_i,
   input  logic [DW-1:0] acc_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_din_i,
   input  logic          cpu_wm_i,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_din_o,
   output logic          ram_wen_o,
   input  logic [DW-1:0] ram_dout_i,
   output logic          ram_sel_o
);

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_MEM    = 2'd3
   } state_t;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_RUN   = 3'd1;
   localparam logic [2:0] OP_HALT  = 3'd2;
   localparam logic [2:0] OP_STEP  = 3'd3;
   localparam logic [2:0] OP_MEMRD = 3'd4;
   localparam logic [2:0] OP_MEMWR = 3'd5;
   localparam logic [2:0] OP_RDACC = 3'd6;
   localparam logic [2:0] OP_SETBP = 3'd7;

   state_t          state_q;
   state_t          state_d;
   state_t          ret_q;
   state_t          ret_d;

   logic            bp_en_q;
   logic [AW-1:0]   bp_addr_q;
   logic            skip_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DW-1:0]   mem_dat_q;
   logic            mem_wr_q;
   logic            rsp_vld_q;
   logic [DW-1:0]   rsp_dat_q;

   logic            cmd_acc;
   logic            cmd_is_mem;
   logic            bp_hit;
   logic            enter_run_step;
   logic            rsp_set;
   logic [DW-1:0]   rsp_nxt;

   assign cmd_acc    = cmd_valid_i && cmd_ready_o;
   assign cmd_is_mem = (cmd_op_i == OP_MEMRD) || (cmd_op_i == OP_MEMWR);

   // skip_q masks the breakpoint for the instruction we resume on.
   assign bp_hit = bp_en_q && (pc_i == bp_addr_q) && !skip_q;

   assign enter_run_step = (state_d != state_q) &&
                           ((state_d == ST_RUN) || (state_d == ST_STEP));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RST_RUN ? ST_RUN : ST_HALTED;
         ret_q   <= ST_HALTED;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      case (state_q)
         ST_HALTED: begin
            if (cmd_acc) begin
               case (cmd_op_i)
                  OP_RUN:  state_d = ST_RUN;
                  OP_STEP: state_d = ST_STEP;
                  OP_MEMRD, OP_MEMWR: begin
                     state_d = ST_MEM;
                     ret_d   = ST_HALTED;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // A breakpoint absorbs RUN/HALT/STEP but a memory op still runs, returning to HALTED.
            if (bp_hit) begin
               state_d = ST_HALTED;
            end
            if (cmd_acc) begin
               case (cmd_op_i)
                  OP_HALT, OP_STEP: state_d = ST_HALTED;
                  OP_MEMRD, OP_MEMWR: begin
                     state_d = ST_MEM;
                     ret_d   = bp_hit ? ST_HALTED : ST_RUN;
                  end
                  default: ;
               endcase
            end
         end
         ST_STEP: state_d = ST_HALTED;
         default: state_d = ret_q;
      endcase
   end

   always_comb begin
      cmd_ready_o = 1'b0;
      halted_o    = 1'b0;
      cpu_en_o    = 1'b0;
      ram_sel_o   = 1'b0;
      ram_addr_o  = cpu_addr_i;
      ram_din_o   = cpu_din_i;
      ram_wen_o   = 1'b0;
      case (state_q)
         ST_HALTED: begin
            cmd_ready_o = 1'b1;
            halted_o    = 1'b1;
         end
         ST_RUN: begin
            cmd_ready_o = 1'b1;
            cpu_en_o    = !bp_hit;
            ram_wen_o   = cpu_wm_i && !bp_hit;
         end
         ST_STEP: begin
            cpu_en_o  = 1'b1;
            ram_wen_o = cpu_wm_i;
         end
         default: begin
            ram_sel_o  = 1'b1;
            ram_addr_o = mem_addr_q;
            ram_din_o  = mem_dat_q;
            ram_wen_o  = mem_wr_q;
         end
      endcase
      if (rst_i) begin
         cpu_en_o  = 1'b0;
         ram_wen_o = 1'b0;
      end
   end

   // At most one response source can fire per cycle except bp vs RDACC, where the breakpoint wins.
   always_comb begin
      rsp_set = 1'b0;
      rsp_nxt = rsp_dat_q;
      if ((state_q == ST_RUN) && bp_hit) begin
         rsp_set = 1'b1;
         rsp_nxt = {{(DW-AW){1'b0}}, pc_i};
      end else if ((state_q == ST_MEM) && !mem_wr_q) begin
         rsp_set = 1'b1;
         rsp_nxt = ram_dout_i;
      end else if (cmd_acc && (cmd_op_i == OP_RDACC)) begin
         rsp_set = 1'b1;
         rsp_nxt = acc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bp_en_q    <= 1'b0;
         bp_addr_q  <= '0;
         skip_q     <= 1'b1;
         mem_addr_q <= '0;
         mem_dat_q  <= '0;
         mem_wr_q   <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_dat_q  <= '0;
      end else begin
         rsp_vld_q <= rsp_set;
         if (rsp_set) begin
            rsp_dat_q <= rsp_nxt;
         end
         if (cmd_acc && (cmd_op_i == OP_SETBP)) begin
            bp_addr_q <= cmd_addr_i;
            bp_en_q   <= cmd_data_i[0];
         end
         if (cmd_acc && cmd_is_mem) begin
            mem_addr_q <= cmd_addr_i;
            mem_dat_q  <= cmd_data_i;
            mem_wr_q   <= (cmd_op_i == OP_MEMWR);
         end
         if (enter_run_step) begin
            skip_q <= 1'b1;
         end else if ((state_q == ST_RUN) && cpu_en_o) begin
            skip_q <= 1'b0;
         end
      end
   end

   assign rsp_valid_o = rsp_vld_q;
   assign rsp_data_o  = rsp_dat_q;

   a_sel_stalls_cpu: assert property (@(posedge clk_i) disable iff (rst_i)
      ram_sel_o |-> !cpu_en_o);
   a_cpu_wr_needs_en: assert property (@(posedge clk_i) disable iff (rst_i)
      (ram_wen_o && !ram_sel_o) |-> cpu_en_o);

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed test-plan checks with literal expectations, then randomized traffic against a flag-level reference model.
module tb_run_ctrl;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_RUN   = 3'd1;
   localparam logic [2:0] OP_HALT  = 3'd2;
   localparam logic [2:0] OP_STEP  = 3'd3;
   localparam logic [2:0] OP_MEMRD = 3'd4;
   localparam logic [2:0] OP_MEMWR = 3'd5;
   localparam logic [2:0] OP_RDACC = 3'd6;
   localparam logic [2:0] OP_SETBP = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [2:0] cmd_op_i;
   logic [4:0] cmd_addr_i;
   logic [7:0] cmd_data_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;
   logic       halted_o;
   logic       cpu_en_o;
   logic [4:0] pc_i;
   logic [7:0] acc_i;
   logic [4:0] cpu_addr_i;
   logic [7:0] cpu_din_i;
   logic       cpu_wm_i;
   logic [4:0] ram_addr_o;
   logic [7:0] ram_din_o;
   logic       ram_wen_o;
   logic [7:0] ram_dout_i;
   logic       ram_sel_o;

   logic [7:0] env_ram [32];
   assign ram_dout_i = env_ram[ram_addr_o];

   run_ctrl #(.AW(5), .DW(8), .RST_RUN(1'b0)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .halted_o(halted_o), .cpu_en_o(cpu_en_o),
      .pc_i(pc_i), .acc_i(acc_i), .cpu_addr_i(cpu_addr_i), .cpu_din_i(cpu_din_i), .cpu_wm_i(cpu_wm_i),
      .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_wen_o(ram_wen_o),
      .ram_dout_i(ram_dout_i), .ram_sel_o(ram_sel_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit jumpy = 1'b0;

   // Reference model: what the controller is doing, as plain flags.
   bit         m_run, m_step, m_mem, m_mem_wr, m_resume, m_bp_en, m_fresh, m_rsp_due;
   logic [4:0] m_mem_addr, m_bp_addr;
   logic [7:0] m_mem_data, m_rsp_val;
   logic [7:0] m_ram [32];

   logic       e_halted, e_ready, e_bp, e_cpu_en, e_sel, e_wen;
   logic [4:0] e_addr;
   logic [7:0] e_din;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_step = 1'b0; m_mem = 1'b0; m_resume = 1'b0;
      m_bp_en = 1'b0; m_bp_addr = 5'd0; m_fresh = 1'b1;
      m_rsp_due = 1'b0; m_rsp_val = 8'd0;
   endtask

   task automatic model_outputs();
      e_halted = !m_run && !m_step && !m_mem;
      e_ready  = !m_step && !m_mem;
      e_bp     = m_run && m_bp_en && (pc_i == m_bp_addr) && !m_fresh;
      e_cpu_en = !rst_i && ((m_run && !e_bp) || m_step);
      e_sel    = m_mem;
      e_addr   = m_mem ? m_mem_addr : cpu_addr_i;
      e_din    = m_mem ? m_mem_data : cpu_din_i;
      e_wen    = !rst_i && (m_mem ? m_mem_wr : (cpu_wm_i && e_cpu_en));
   endtask

   task automatic model_step();
      bit acc, due;
      logic [7:0] val;
      if (rst_i) begin
         model_reset();
         return;
      end
      acc = cmd_valid_i && e_ready;
      due = 1'b0;
      val = m_rsp_val;
      if (e_bp) begin due = 1'b1; val = {3'b000, pc_i}; end
      if (m_mem && !m_mem_wr) begin due = 1'b1; val = m_ram[m_mem_addr]; end
      if (acc && cmd_op_i == OP_RDACC && !e_bp) begin due = 1'b1; val = acc_i; end
      if (e_wen) m_ram[e_addr] = e_din;
      if (m_step) begin
         m_step = 1'b0;
      end else if (m_mem) begin
         m_mem = 1'b0;
         m_run = m_resume;
         if (m_resume) m_fresh = 1'b1;
      end else if (m_run) begin
         if (e_cpu_en) m_fresh = 1'b0;
         if (e_bp) m_run = 1'b0;
         if (acc && (cmd_op_i == OP_HALT || cmd_op_i == OP_STEP)) m_run = 1'b0;
         if (acc && (cmd_op_i == OP_MEMRD || cmd_op_i == OP_MEMWR)) begin
            m_mem = 1'b1; m_resume = !e_bp; m_run = 1'b0;
         end
      end else if (acc) begin
         if (cmd_op_i == OP_RUN) begin m_run = 1'b1; m_fresh = 1'b1; end
         if (cmd_op_i == OP_STEP) begin m_step = 1'b1; m_fresh = 1'b1; end
         if (cmd_op_i == OP_MEMRD || cmd_op_i == OP_MEMWR) begin m_mem = 1'b1; m_resume = 1'b0; end
      end
      if (acc && (cmd_op_i == OP_MEMRD || cmd_op_i == OP_MEMWR)) begin
         m_mem_addr = cmd_addr_i; m_mem_data = cmd_data_i; m_mem_wr = (cmd_op_i == OP_MEMWR);
      end
      if (acc && cmd_op_i == OP_SETBP) begin
         m_bp_en = cmd_data_i[0]; m_bp_addr = cmd_addr_i;
      end
      m_rsp_due = due;
      m_rsp_val = val;
   endtask

   task automatic compare();
      chk("cpu_en", 32'(cpu_en_o), 32'(e_cpu_en));
      chk("ram_wen", 32'(ram_wen_o), 32'(e_wen));
      if (!rst_i) begin
         chk("halted", 32'(halted_o), 32'(e_halted));
         chk("cmd_ready", 32'(cmd_ready_o), 32'(e_ready));
         chk("ram_sel", 32'(ram_sel_o), 32'(e_sel));
         chk("ram_addr", 32'(ram_addr_o), 32'(e_addr));
         chk("ram_din", 32'(ram_din_o), 32'(e_din));
         chk("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp_due));
         chk("rsp_data", 32'(rsp_data_o), 32'(m_rsp_val));
      end
   endtask

   // One clock: compare and advance the model mid-cycle, then update the CPU/RAM environment after the edge.
   task automatic cycle();
      logic       w, adv;
      logic [4:0] wa;
      logic [7:0] wd;
      @(negedge clk);
      model_outputs();
      compare();
      w = ram_wen_o; wa = ram_addr_o; wd = ram_din_o;
      adv = e_cpu_en;
      model_step();
      @(posedge clk);
      #1;
      if (w === 1'b1) env_ram[wa] = wd;
      if (adv) pc_i = (jumpy && $urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pc_i + 5'd1;
   endtask

   task automatic send(input logic [2:0] op, input logic [4:0] addr, input logic [7:0] data);
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = data;
      cycle();
      cmd_valid_i = 1'b0;
   endtask

   initial begin
      logic [4:0] held_pc;
      bit found;
      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = OP_NOP; cmd_addr_i = 5'd0; cmd_data_i = 8'd0;
      pc_i = 5'd0; acc_i = 8'd0; cpu_addr_i = 5'd0; cpu_din_i = 8'd0; cpu_wm_i = 1'b0;
      for (int i = 0; i < 32; i++) begin env_ram[i] = 8'd0; m_ram[i] = 8'd0; end
      model_reset();
      m_mem_addr = 5'd0; m_mem_data = 8'd0; m_mem_wr = 1'b0;
      cycle();
      cycle();
      rst_i = 1'b0;

      // Reset state, then a single step
      #1;
      chk("rst_halted", 32'(halted_o), 32'd1);
      chk("rst_cpu_en", 32'(cpu_en_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      send(OP_STEP, 5'd0, 8'd0);
      #1;
      chk("step_en", 32'(cpu_en_o), 32'd1);
      cycle();
      #1;
      chk("step_done_en", 32'(cpu_en_o), 32'd0);
      chk("step_done_halted", 32'(halted_o), 32'd1);

      // Breakpoint at 5, run from pc 0
      pc_i = 5'd0;
      send(OP_SETBP, 5'd5, 8'd1);
      send(OP_RUN, 5'd0, 8'd0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         #1;
         if (halted_o === 1'b1) found = 1'b1;
         else cycle();
      end
      chk("bp_reached", 32'(found), 32'd1);
      chk("bp_pc", 32'(pc_i), 32'd5);
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data_o), 32'h05);
      send(OP_RUN, 5'd0, 8'd0);
      #1;
      chk("resume_en", 32'(cpu_en_o), 32'd1);
      cycle();
      #1;
      chk("resume_pc", 32'(pc_i), 32'd6);
      send(OP_HALT, 5'd0, 8'd0);

      // Host write then read back while halted
      send(OP_MEMWR, 5'd3, 8'hA5);
      #1;
      chk("wr_sel", 32'(ram_sel_o), 32'd1);
      chk("wr_wen", 32'(ram_wen_o), 32'd1);
      chk("wr_addr", 32'(ram_addr_o), 32'd3);
      chk("wr_din", 32'(ram_din_o), 32'hA5);
      cycle();
      send(OP_MEMRD, 5'd3, 8'd0);
      cycle();
      #1;
      chk("rd_valid", 32'(rsp_valid_o), 32'd1);
      chk("rd_data", 32'(rsp_data_o), 32'hA5);

      // Host read stalls a running CPU that wants to write
      send(OP_SETBP, 5'd0, 8'd0);
      cpu_wm_i = 1'b1;
      send(OP_RUN, 5'd0, 8'd0);
      send(OP_MEMRD, 5'd7, 8'd0);
      #1;
      chk("stall_en", 32'(cpu_en_o), 32'd0);
      chk("stall_wen", 32'(ram_wen_o), 32'd0);
      chk("stall_sel", 32'(ram_sel_o), 32'd1);
      held_pc = pc_i;
      cycle();
      #1;
      chk("stall_pc_held", 32'(pc_i), 32'(held_pc));
      chk("stall_resume_en", 32'(cpu_en_o), 32'd1);
      cpu_wm_i = 1'b0;
      send(OP_HALT, 5'd0, 8'd0);

      // Accumulator read
      acc_i = 8'h3C;
      send(OP_RDACC, 5'd0, 8'd0);
      #1;
      chk("rdacc_valid", 32'(rsp_valid_o), 32'd1);
      chk("rdacc_data", 32'(rsp_data_o), 32'h3C);
      chk("rdacc_halted", 32'(halted_o), 32'd1);

      // Reset lands on the MEM cycle of a host write
      send(OP_MEMWR, 5'd9, 8'h5A);
      rst_i = 1'b1;
      #1;
      chk("rstmem_wen", 32'(ram_wen_o), 32'd0);
      cycle();
      rst_i = 1'b0;
      #1;
      chk("rstmem_halted", 32'(halted_o), 32'd1);
      chk("rstmem_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rstmem_rsp_data", 32'(rsp_data_o), 32'd0);
      chk("rstmem_cpu_en", 32'(cpu_en_o), 32'd0);
      chk("rstmem_sel", 32'(ram_sel_o), 32'd0);
      chk("rstmem_nowrite", 32'(env_ram[9]), 32'd0);

      // Random traffic against the model
      jumpy = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         rst_i       = ($urandom_range(0, 299) == 0);
         cmd_valid_i = ($urandom_range(0, 1) == 1);
         cmd_op_i    = 3'($urandom_range(0, 7));
         cmd_addr_i  = 5'($urandom_range(0, 31));
         cmd_data_i  = 8'($urandom_range(0, 255));
         acc_i       = 8'($urandom_range(0, 255));
         cpu_addr_i  = 5'($urandom_range(0, 31));
         cpu_din_i   = 8'($urandom_range(0, 255));
         cpu_wm_i    = ($urandom_range(0, 1) == 1);
         cycle();
      end
      rst_i = 1'b0;
      cmd_valid_i = 1'b0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run-control and RAM arbiter for the 8-bit accumulator CPU.
- Gates CPU execution through a clock-enable: run, halt, single-step, PC breakpoint.
- Shares the 32x8 data RAM between the CPU and a host debug command port.
- Sits between the CPU datapath (PC/ACC/RAM write path) and the host/loader interface; stalls the CPU for one cycle whenever the host takes the RAM.

Parameters:
AW, 5, RAM/PC address width
DW, 8, data/accumulator width
RST_RUN, 0, 1 = enter RUN after reset, 0 = enter HALTED

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  host command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  3  0 NOP,1 RUN,2 HALT,3 STEP,4 MEMRD,5 MEMWR,6 RDACC,7 SETBP
cmd_addr_i  in  AW  RAM address / breakpoint address
cmd_data_i  in  DW  write data; SETBP: bit0 = bp enable
rsp_valid_o  out  1  one-cycle response pulse (no backpressure)
rsp_data_o  out  DW  response data
halted_o  out  1  1 when state is HALTED
cpu_en_o  out  1  CPU advance enable (PC, ACC, CPU RAM write)
pc_i  in  AW  current CPU PC
acc_i  in  DW  current accumulator
cpu_addr_i  in  AW  CPU RAM address
cpu_din_i  in  DW  CPU RAM write data
cpu_wm_i  in  1  CPU RAM write request
ram_addr_o  out  AW  muxed RAM address
ram_din_o  out  DW  muxed RAM write data
ram_wen_o  out  1  muxed RAM write enable
ram_dout_i  in  DW  RAM read data (combinational read)
ram_sel_o  out  1  1 = host owns RAM this cycle

Behaviour:
- States: HALTED, RUN, STEP, MEM. Register ret_q holds the state to return to after MEM (RUN or HALTED).
- Reset:
  - state = RUN if RST_RUN else HALTED.
  - bp_en=0, bp_addr=0, rsp_valid_o=0, rsp_data_o=0, skip_q=1.
  - cpu_en_o and ram_wen_o forced 0 while rst_i is high, which aborts any in-flight MEM write.
- cmd_ready_o = 1 in HALTED and RUN; 0 in STEP and MEM.
- Timing: a command accepted at edge t takes effect from cycle t+1.
- bp_hit = bp_en & (pc_i==bp_addr) & !skip_q.
- cpu_en_o = (RUN & !bp_hit) | STEP.
- RUN:
  - On bp_hit: go HALTED next cycle, with rsp_valid_o=1 and rsp_data_o={0,pc_i}. The PC does not advance.
  - skip_q clears after the first RUN cycle with cpu_en_o=1. skip_q sets on every entry to RUN or STEP, so the breakpoint instruction executes on resume.
- Commands:
  - RUN: HALTED->RUN; no-op if already in RUN.
  - HALT: RUN->HALTED; the CPU executes in the accept cycle and stops from t+1.
  - STEP:
    - From HALTED: STEP for exactly 1 cycle (cpu_en_o=1), then HALTED. Breakpoint ignored.
    - From RUN: treated as HALT.
  - MEMRD/MEMWR: latch addr/data, set ret_q = current state, enter MEM for 1 cycle, then return to ret_q.
    - In MEM: cpu_en_o=0, ram_sel_o=1, ram_addr_o=latched addr.
    - MEMWR: ram_din_o=latched data, ram_wen_o=1.
    - MEMRD: ram_dout_i is registered into rsp_data_o, with rsp_valid_o=1 on the following cycle.
    - MEMWR produces no response.
  - RDACC: rsp_data_o=acc_i sampled at the accept edge; rsp_valid_o=1 next cycle; no state change, no stall.
  - SETBP: bp_addr=cmd_addr_i, bp_en=cmd_data_i[0]; no response; takes effect from t+1.
  - NOP: accepted, no effect.
- RAM mux:
  - When ram_sel_o=0: ram_addr_o=cpu_addr_i, ram_din_o=cpu_din_i, ram_wen_o=cpu_wm_i & cpu_en_o.
  - A CPU write is never issued while stalled or halted.
- Simultaneous events:
  - bp_hit in the same cycle a command is accepted in RUN: breakpoint wins. HALT/RUN/STEP are absorbed; MEM ops still execute, with ret_q=HALTED.
  - Breakpoint response and MEMRD response never collide, since MEM follows acceptance.
- rsp_valid_o is high for exactly 1 cycle per response.
- Throughput: back-to-back MEM ops are separated by at least 1 cycle because cmd_ready_o=0 in MEM. In RUN, the CPU progresses at least every other cycle.

Test Plan:
- Reset with RST_RUN=0 -> halted_o=1, cpu_en_o=0, rsp_valid_o=0. Issue STEP -> cpu_en_o high exactly one cycle, then HALTED.
- SETBP addr=5,data=1; RUN from pc=0 -> cpu_en_o high until pc_i=5, then 0. rsp pulse with data 0x05; halted_o=1. RUN again -> pc advances past 5.
- MEMWR addr=3,data=0xA5 while HALTED, then MEMRD addr=3 -> ram_wen_o one cycle with ram_addr_o=3. rsp_data_o=0xA5 one cycle after MEM.
- MEMRD while RUN with cpu_wm_i=1 -> cpu_en_o=0 and ram_wen_o=0 in the MEM cycle; RUN resumes next cycle; PC held for exactly one cycle.
- RDACC with acc_i=0x3C -> rsp_valid_o pulse, rsp_data_o=0x3C; state unchanged.
- Assert rst_i during the MEM cycle of a MEMWR -> ram_wen_o=0 that cycle; all outputs at reset values next cycle.
